// File: rtl/alu_uart_interface.sv
// -----------------------------------------------------------------------------
// alu_uart_interface
//
// Sequencer between a UART RX/TX pair and a combinational ALU. Three received
// bytes are collected in order (operand 1, operand 2, operation code). They are
// presented to the ALU as registered inputs. The ALU result is then captured
// and handed to the UART TX as one byte with a single-cycle start pulse.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_rx_data     byte from UART RX, valid while i_rx_done=1
//   i_rx_done     one-cycle pulse, new RX byte available
//   i_tx_done     one-cycle pulse, UART TX finished the byte
//   i_alu_result  combinational ALU output
//   o_alu_data_1  registered ALU operand 1
//   o_alu_data_2  registered ALU operand 2
//   o_alu_ctrl    registered ALU operation code
//   o_tx_data     byte for UART TX, held until the next result
//   o_tx_start    one-cycle pulse requesting transmission of o_tx_data
//   o_busy        high while a result is being sent (S_SEND, S_WAIT_TX)
//   o_rx_drop     one-cycle pulse when an RX byte is discarded
// -----------------------------------------------------------------------------
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_data_1,
    output logic [NB_DATA-1:0] o_alu_data_2,
    output logic [NB_OP-1:0]   o_alu_ctrl,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_drop
);

    typedef enum logic [2:0] {
        S_DATA_1,
        S_DATA_2,
        S_OPCODE,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t             state, state_next;
    logic [NB_DATA-1:0] data_1_next, data_2_next, tx_data_next;
    logic [NB_OP-1:0]   ctrl_next;
    logic               tx_start_next, busy_next, rx_drop_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next    = state;
        data_1_next   = o_alu_data_1;
        data_2_next   = o_alu_data_2;
        ctrl_next     = o_alu_ctrl;
        tx_data_next  = o_tx_data;
        tx_start_next = 1'b0;
        rx_drop_next  = 1'b0;

        case (state)
            S_DATA_1: begin
                if (i_rx_done) begin
                    data_1_next = i_rx_data;
                    state_next  = S_DATA_2;
                end
            end
            S_DATA_2: begin
                if (i_rx_done) begin
                    data_2_next = i_rx_data;
                    state_next  = S_OPCODE;
                end
            end
            S_OPCODE: begin
                if (i_rx_done) begin
                    // Upper bits of the opcode byte are not part of the ALU code.
                    ctrl_next  = i_rx_data[NB_OP-1:0];
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                // ALU inputs have been stable since the opcode edge, so the
                // result sampled here belongs to this transaction.
                tx_data_next  = i_alu_result;
                tx_start_next = 1'b1;
                // A byte arriving while the result is being latched cannot be
                // used either; it is flagged like any other discarded byte.
                rx_drop_next  = i_rx_done;
                state_next    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                rx_drop_next = i_rx_done;
                if (i_tx_done) begin
                    state_next = S_DATA_1;
                end
            end
            default: begin
                state_next = S_DATA_1;
            end
        endcase

        // Registered busy follows the state being entered, so it is high from
        // the S_SEND cycle through the cycle in which i_tx_done is sampled.
        busy_next = (state_next == S_SEND) || (state_next == S_WAIT_TX);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge only; it overrides any coincident RX byte.
        if (i_rst) begin
            state        <= S_DATA_1;
            o_alu_data_1 <= '0;
            o_alu_data_2 <= '0;
            o_alu_ctrl   <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_rx_drop    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state        <= state_next;
            o_alu_data_1 <= data_1_next;
            o_alu_data_2 <= data_2_next;
            o_alu_ctrl   <= ctrl_next;
            o_tx_data    <= tx_data_next;
            o_tx_start   <= tx_start_next;
            o_busy       <= busy_next;
            o_rx_drop    <= rx_drop_next;
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_interface
//
// Self-checking bench for alu_uart_interface. A small combinational ALU model
// closes the loop on i_alu_result. A transaction-level reference model tracks
// how many operand bytes have been collected and whether a result is being
// sent. It predicts every registered output after each clock edge, and one
// compare process checks all outputs on the falling edge. Directed
// transactions add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_alu_uart_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    logic               i_clk;
    logic               i_rst;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_data_1;
    logic [NB_DATA-1:0] o_alu_data_2;
    logic [NB_OP-1:0]   o_alu_ctrl;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_rx_drop;

    int n_checks = 0;
    int n_errors = 0;

    alu_uart_interface #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .o_alu_data_1 (o_alu_data_1),
        .o_alu_data_2 (o_alu_data_2),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_rx_drop    (o_rx_drop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ALU behaviour: unknown opcodes return 0.
    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return $unsigned($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu(o_alu_data_1, o_alu_data_2, o_alu_ctrl);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bytes_got counts collected operand bytes (0..2),
    // pending_send marks a complete request whose result is latched next,
    // sending marks a result handed to TX and not yet acknowledged.
    // ------------------------------------------------------------------
    logic       model_valid = 1'b0;
    int         bytes_got;
    bit         pending_send, sending;
    logic [7:0] exp_d1, exp_d2, exp_tx;
    logic [5:0] exp_ctrl;
    bit         exp_start, exp_busy, exp_drop;

    always @(posedge i_clk) begin
        if (i_rst) begin
            model_valid  = 1'b1;
            bytes_got    = 0;
            pending_send = 0;
            sending      = 0;
            exp_d1       = 8'h00;
            exp_d2       = 8'h00;
            exp_ctrl     = 6'h00;
            exp_tx       = 8'h00;
            exp_start    = 0;
            exp_busy     = 0;
            exp_drop     = 0;
        end else if (model_valid) begin
            exp_start = 0;
            exp_drop  = 0;
            if (pending_send) begin
                exp_tx       = alu(exp_d1, exp_d2, exp_ctrl);
                exp_start    = 1;
                exp_drop     = i_rx_done;
                pending_send = 0;
                sending      = 1;
            end else if (sending) begin
                exp_drop = i_rx_done;
                if (i_tx_done) sending = 0;
            end else if (i_rx_done) begin
                if (bytes_got == 0) begin
                    exp_d1    = i_rx_data;
                    bytes_got = 1;
                end else if (bytes_got == 1) begin
                    exp_d2    = i_rx_data;
                    bytes_got = 2;
                end else begin
                    exp_ctrl     = i_rx_data[5:0];
                    bytes_got    = 0;
                    pending_send = 1;
                end
            end
            exp_busy = pending_send || sending;
        end
    end

    always @(negedge i_clk) begin
        if (model_valid) begin
            check("m_alu_data_1", o_alu_data_1, exp_d1);
            check("m_alu_data_2", o_alu_data_2, exp_d2);
            check("m_alu_ctrl",   o_alu_ctrl,   exp_ctrl);
            check("m_tx_data",    o_tx_data,    exp_tx);
            check("m_tx_start",   o_tx_start,   exp_start);
            check("m_busy",       o_busy,       exp_busy);
            check("m_rx_drop",    o_rx_drop,    exp_drop);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drive right after a falling edge)
    // ------------------------------------------------------------------
    task automatic rx(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Full transaction with literal checks on latency and result;
    // i_tx_done is returned tx_delay cycles after the start pulse.
    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] res, input int tx_delay);
        rx(a);
        rx(b);
        rx(op);
        check("busy_at_send", o_busy, 1);
        check("start_not_early", o_tx_start, 0);
        @(negedge i_clk);
        check("start_at_2", o_tx_start, 1);
        check("tx_result", o_tx_data, res);
        @(negedge i_clk);
        check("start_single", o_tx_start, 0);
        repeat (tx_delay - 1) @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check("busy_after_tx", o_busy, 0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        idle(2);
        i_rst = 1'b0;

        check("rst_data_1", o_alu_data_1, 0);
        check("rst_ctrl", o_alu_ctrl, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_busy", o_busy, 0);

        // ADD, SUB wrap, AND with upper opcode bits set, NOR, unknown op
        txn(8'h05, 8'h03, 8'h20, 8'h08, 1);
        check("add_ctrl", o_alu_ctrl, 6'h20);
        txn(8'h03, 8'h05, 8'h22, 8'hFE, 2);
        txn(8'hF0, 8'h3C, 8'hE4, 8'h30, 3);
        check("and_ctrl_masked", o_alu_ctrl, 6'h24);
        txn(8'hF0, 8'h0F, 8'h27, 8'h00, 1);
        txn(8'h12, 8'h34, 8'h3F, 8'h00, 1);
        // Back in S_DATA_1: next byte must land in operand 1
        rx(8'hC3);
        check("back_to_data_1", o_alu_data_1, 8'hC3);
        rx(8'h01);
        rx(8'h00);
        idle(1);
        i_tx_done = 1'b1;
        idle(1);
        i_tx_done = 1'b0;

        // Drops during S_WAIT_TX
        rx(8'h01);
        rx(8'h02);
        rx(8'h20);
        idle(1);
        rx(8'h55);
        check("drop_1", o_rx_drop, 1);
        check("drop_keeps_d1", o_alu_data_1, 8'h01);
        idle(1);
        check("drop_1_ends", o_rx_drop, 0);
        rx(8'h66);
        check("drop_2", o_rx_drop, 1);
        check("drop_keeps_d2", o_alu_data_2, 8'h02);
        i_tx_done = 1'b1;
        rx(8'h77);
        i_tx_done = 1'b0;
        check("drop_with_tx_done", o_rx_drop, 1);
        check("busy_clear_on_coincident", o_busy, 0);
        check("dropped_not_operand", o_alu_data_1, 8'h01);
        txn(8'h01, 8'h01, 8'h20, 8'h02, 1);

        // Reset mid-operation, with a coincident RX byte ignored
        rx(8'hAA);
        rx(8'h55);
        i_rst     = 1'b1;
        i_rx_data = 8'h99;
        i_rx_done = 1'b1;
        idle(1);
        i_rst     = 1'b0;
        i_rx_done = 1'b0;
        check("rst_mid_d1", o_alu_data_1, 0);
        check("rst_mid_d2", o_alu_data_2, 0);
        check("rst_mid_tx", o_tx_data, 0);
        txn(8'h07, 8'h02, 8'h22, 8'h05, 1);

        // Reset during S_WAIT_TX
        rx(8'h09);
        rx(8'h01);
        rx(8'h20);
        idle(2);
        check("wait_busy", o_busy, 1);
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
        check("rst_wait_busy", o_busy, 0);

        // Back-to-back transactions
        txn(8'h10, 8'h20, 8'h20, 8'h30, 1);
        txn(8'hFF, 8'h01, 8'h20, 8'h00, 1);
        txn(8'h0F, 8'hF0, 8'h26, 8'hFF, 1);

        // Randomized phase, checked by the reference model every cycle
        for (int i = 0; i < 4000; i++) begin
            i_rx_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 7))
                    0: i_rx_data = {2'($urandom), 6'h20};
                    1: i_rx_data = {2'($urandom), 6'h22};
                    2: i_rx_data = {2'($urandom), 6'h24};
                    3: i_rx_data = {2'($urandom), 6'h25};
                    4: i_rx_data = {2'($urandom), 6'h26};
                    5: i_rx_data = {2'($urandom), 6'h27};
                    6: i_rx_data = {2'($urandom), 6'h02};
                    default: i_rx_data = {2'($urandom), 6'h03};
                endcase
            end else begin
                i_rx_data = 8'($urandom);
            end
            i_tx_done = ($urandom_range(0, 3) == 0);
            i_rst     = ($urandom_range(0, 299) == 0);
            @(negedge i_clk);
        end
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        i_rst     = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Sequencer between the UART receiver/transmitter pair and the combinational ALU. It collects three bytes from the UART RX: operand 1, operand 2 and the operation code. It drives them as registered ALU inputs, captures the ALU result and hands it to the UART TX as a single byte. It is the initiator side of the ALU's operand/control interface and sits between the UART blocks and the ALU in the top level.

## Interface
- NB_DATA, 8, width of UART bytes, ALU operands and ALU result
- NB_OP, 6, width of ALU operation code
- i_clk  input  1  single system clock; all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_rx_data  input  NB_DATA  byte from UART RX; valid only when i_rx_done=1
- i_rx_done  input  1  one-cycle pulse, new RX byte available
- i_tx_done  input  1  one-cycle pulse, UART TX finished sending the byte
- i_alu_result  input  NB_DATA  combinational ALU output
- o_alu_data_1  output  NB_DATA  registered ALU operand 1
- o_alu_data_2  output  NB_DATA  registered ALU operand 2
- o_alu_ctrl  output  NB_OP  registered ALU operation code
- o_tx_data  output  NB_DATA  byte for UART TX; held until next result
- o_tx_start  output  1  one-cycle pulse requesting TX of o_tx_data
- o_busy  output  1  high while a result is being sent (S_SEND, S_WAIT_TX)
- o_rx_drop  output  1  one-cycle pulse when an RX byte is discarded

## Operation
- States: S_DATA_1, S_DATA_2, S_OPCODE, S_SEND, S_WAIT_TX. All outputs are registered.
- Reset state is S_DATA_1. Reset values: o_alu_data_1=0, o_alu_data_2=0, o_alu_ctrl=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_rx_drop=0.
- S_DATA_1 on i_rx_done:
  - o_alu_data_1 <= i_rx_data.
  - -> S_DATA_2.
- S_DATA_2 on i_rx_done:
  - o_alu_data_2 <= i_rx_data.
  - -> S_OPCODE.
- S_OPCODE on i_rx_done:
  - o_alu_ctrl <= i_rx_data[NB_OP-1:0]; upper bits are ignored.
  - -> S_SEND.
- S_SEND is unconditional and lasts exactly 1 cycle:
  - o_tx_data <= i_alu_result. The ALU inputs are already stable from the registered ctrl.
  - o_tx_start <= 1.
  - -> S_WAIT_TX.
- S_WAIT_TX:
  - On i_tx_done -> S_DATA_1.
  - Any i_rx_done in this state is discarded and pulses o_rx_drop for one cycle.
- Without i_rx_done, the S_DATA_1/S_DATA_2/S_OPCODE states hold indefinitely. There is no timeout.
- i_tx_done outside S_WAIT_TX is ignored.
- ALU inputs keep their last values after a transaction until overwritten by the next received byte. The ALU therefore shows partial new operands with the old opcode mid-sequence; this is allowed, since only the S_SEND sample is used.
- Unknown opcodes are forwarded unchanged; the ALU returns 0 for them and that 0 is transmitted.

## Timing
- RX byte with i_rx_done at cycle n -> the matching register updates at the n+1 edge and the state advances at the same edge.
- Opcode i_rx_done at cycle m:
  - o_alu_ctrl valid from cycle m+1 (S_SEND).
  - o_tx_data and o_tx_start=1 during cycle m+2.
  - o_tx_start=0 from m+3.
- Latency from opcode i_rx_done to o_tx_start is 2 cycles. o_tx_start is never high for more than 1 cycle.
- o_busy is high from cycle m+1 through the cycle in which i_tx_done is sampled; it is low from the next cycle.
- i_tx_done and i_rx_done in the same S_WAIT_TX cycle: the byte is dropped (o_rx_drop pulses) and the state -> S_DATA_1. The next byte becomes operand 1.
- o_rx_drop goes high the cycle after the dropped i_rx_done, for 1 cycle.
- i_rst high at any edge, including mid-sequence or during S_WAIT_TX:
  - all registers return to reset values at that edge and state = S_DATA_1;
  - an i_rx_done coinciding with i_rst is ignored.
- One transaction at a time; no pipelining of the next operand during TX.

## Test plan
- ADD: bytes 0x05, 0x03, 0x20 -> o_alu_ctrl=0x20, o_tx_data=0x08, o_tx_start pulses exactly 2 cycles after the opcode pulse. After i_tx_done, o_busy=0.
- SUB wrap: bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE. Opcode byte 0xE4 -> o_alu_ctrl=0x24 (AND), and operands 0xF0, 0x3C give o_tx_data=0x30.
- NOR plus unknown op: 0xF0, 0x0F, 0x27 -> 0x00. Then 0x12, 0x34, 0x3F -> 0x00 transmitted, state returns to S_DATA_1.
- Drop: 2 RX pulses during S_WAIT_TX -> 2 o_rx_drop pulses, operands unchanged. i_tx_done coincident with RX -> drop plus return to S_DATA_1. Next transaction 0x01, 0x01, 0x20 -> 0x02.
- Reset mid-operation: after operands 0xAA, 0x55, assert i_rst 1 cycle -> all outputs 0. Then bytes 0x07, 0x02, 0x22 -> 0x05. Reset during S_WAIT_TX -> o_busy=0 the next cycle.
- Back-to-back: 3 transactions with i_rx_done on consecutive cycles in the RX states and i_tx_done 1 cycle after o_tx_start -> correct results, no missed byte, no double o_tx_start.
